tube_scan_drv: RTL

//  Time-multiplexed scan driver for a common-select 7-segment digital tube.

---
 rtl/tube_scan_drv_pkg.sv | 31 +++
 rtl/tube_scan_drv_if.sv | 23 ++
 rtl/tube_scan_drv_hex_to_seg7.sv | 33 +++
 rtl/tube_scan_drv.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tube_scan_drv_pkg.sv
// Shared types and constants for the tube scan driver: FSM states and the active-high 7-segment glyphs.
// No logic, so no latency or backpressure.
package tube_scan_drv_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Glyph bit order is {g,f,e,d,c,b,a}, 1 = segment lit
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // {dp,g..a} with nothing lit, before pin polarity is applied
    localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/tube_scan_drv_if.sv
// Bundles the word-load handshake and the tube pins of the scan driver.
// master = upstream word source and pin consumer; slave = the driver itself.
interface tube_scan_drv_if #(
    parameter int DIGITS = 4
);
    logic                  data_vld;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  data_rdy;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     sel;
    logic                  frame_done;

    modport master (
        output data_vld, data_in, dp_in,
        input  data_rdy, seg, sel, frame_done
    );

    modport slave (
        input  data_vld, data_in, dp_in,
        output data_rdy, seg, sel, frame_done
    );
endinterface

// File: rtl/tube_scan_drv_hex_to_seg7.sv
// Nibble to {g..a} glyph decoder, active-high.
// Purely combinational, zero latency, no backpressure.
module tube_scan_drv_hex_to_seg7
    import tube_scan_drv_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_0;
        case (nib)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/tube_scan_drv.sv
// Multiplexed 7-seg tube scanner with double-buffered word load; pins lag the FSM by 1 cycle.
// data_rdy drops while a word waits for the frame wrap; `LEADING_ZERO_BLANK_EN blanks leading zeros.
module tube_scan_drv
    import tube_scan_drv_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int SEG_ACT_LO = 1,
    parameter int SEL_ACT_LO = 1
) (
    input  logic            clk,
    input  logic            rst,
    tube_scan_drv_if.slave  bus
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_IDLE   = (SEG_ACT_LO != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] SEL_IDLE   = (SEL_ACT_LO != 0) ? '1 : '0;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wrap;

    logic [4*DIGITS-1:0] active_q, pend_q;
    logic [DIGITS-1:0]   active_dp_q, pend_dp_q;
    logic                pend_full_q;
    logic                hs;

    logic [3:0]          cur_nib;
    logic [6:0]          glyph;
    logic [6:0]          seg_a_g;
    logic [7:0]          seg_pat;
    logic [DIGITS-1:0]   sel_pat;

    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   sel_q;
    logic                frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // A new word may only enter pending; it reaches the lit digits at a frame wrap so frames never tear.
    assign hs           = bus.data_vld && bus.data_rdy;
    assign bus.data_rdy = !pend_full_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= '0;
            active_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (wrap && pend_full_q) begin
                active_q    <= pend_q;
                active_dp_q <= pend_dp_q;
            end
            if (hs) begin
                pend_q    <= bus.data_in;
                pend_dp_q <= bus.dp_in;
            end
            pend_full_q <= (pend_full_q && !wrap) || hs;
        end
    end

    assign cur_nib = active_q[4*idx_q +: 4];

    tube_scan_drv_hex_to_seg7 u_dec (
        .nib   (cur_nib),
        .glyph (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_blank;
    logic              hi_zero;

    // Digit k is a leading zero when it and every nibble above it are zero; digit 0 never blanks.
    always_comb begin
        lz_blank = '0;
        hi_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hi_zero     = hi_zero && (active_q[4*k +: 4] == 4'h0);
            lz_blank[k] = hi_zero;
        end
    end

    assign seg_a_g = lz_blank[idx_q] ? 7'h00 : glyph;
`else
    assign seg_a_g = glyph;
`endif

    assign seg_pat = {active_dp_q[idx_q], seg_a_g};
    assign sel_pat = DIGITS'(1) << idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= SEG_IDLE;
            sel_q        <= SEL_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= wrap;
            if (state_q == ST_SHOW) begin
                seg_q <= (SEG_ACT_LO != 0) ? ~seg_pat : seg_pat;
                sel_q <= (SEL_ACT_LO != 0) ? ~sel_pat : sel_pat;
            end else begin
                seg_q <= SEG_IDLE;
                sel_q <= SEL_IDLE;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.sel        = sel_q;
    assign bus.frame_done = frame_done_q;

endmodule
